// File: rtl/ctrl_pkg.sv
// Shared definitions for the RISC-V control path: FSM states, ALU operation
// classes, datapath select encodings and the opcodes the controller accepts.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_JAL,
    S_ALUWB,
    S_BEQ
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  // Immediate format implied by the opcode; formats not listed default to I.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: turns the controller's operation class plus the instruction
// funct fields into the ALUControl code for the single shared ALU.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Forced add/sub for address and compare work, funct fields otherwise.
  // funct7 only selects sub for register-register ops (op5=1); addi ignores it.
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: Moore FSM sequencing PC, IR, the unified memory
// port, register file and ALU over several cycles per instruction, with a
// memory-ready handshake and an illegal-opcode pulse.
module mc_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  state_t state, state_next;
  aluop_t aluop;

  logic pc_write_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic illegal_raw;
  logic op_legal;

  assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);

  // State register; reset aborts any instruction in flight and restarts at FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state and Moore output decode; every output has a default first.
  always_comb begin
    state_next    = state;
    aluop         = ALUOP_ADD;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    case (state)
      S_FETCH: begin
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        ir_write_raw = MemReady;
        pc_write_raw = MemReady;
        if (MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jump target from OldPC + immediate.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
        illegal_raw = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe is held for the whole wait so the memory sees a steady request.
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (MemReady) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        // Link value OldPC+4 is computed while PC loads the target in ALUOut.
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
        state_next   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA      = SRCA_RD1;
        ALUSrcB      = SRCB_RD2;
        aluop        = ALUOP_SUB;
        pc_write_raw = Zero;
        state_next   = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Enables are gated by rst so nothing is written while reset is held,
  // including the cycle in which it is first asserted.
  assign PCWrite  = pc_write_raw  & ~rst;
  assign MemWrite = mem_write_raw & ~rst;
  assign IRWrite  = ir_write_raw  & ~rst;
  assign RegWrite = reg_write_raw & ~rst;
  assign Illegal  = illegal_raw   & ~rst;
  assign ImmSrc   = imm_src(op);

  alu_dec u_alu_dec (
    .aluop       (aluop),
    .funct3      (funct3),
    .funct7      (funct7),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle controller for the RISC-V core: a Moore-style FSM that sequences the shared datapath (PC, instruction register, unified memory port, register file, single ALU) over several cycles per instruction. It replaces the single-cycle `ctrl` decoder when the core runs from one memory port. It adds a memory-ready handshake and an illegal-opcode flag. Supported opcodes: lw, sw, R-type, I-type ALU, jal, beq.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset; asynchronous, active-high; one clock domain
- `op`  in  7  opcode from instruction register
- `funct3`  in  3  instruction funct3
- `funct7`  in  1  instruction bit 30 (funct7[5])
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory access completes this cycle
- `PCWrite`  out  1  PC load enable
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = Result
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register / OldPC load enable
- `RegWrite`  out  1  register file write enable
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = RD1
- `ALUSrcB`  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- `ImmSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J (decoded from `op` in every state)
- `ALUControl`  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- `Illegal`  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- Outputs are purely combinational from state, plus `MemReady`, `Zero`, `op` and funct fields. Unlisted enables are 0. Unlisted selects are 00.
- ALUOp is internal: add, sub, or funct.
  - funct decode: funct3 000 gives sub if `op[5] & funct7`, else add.
  - funct3 010 gives slt, 110 gives or, 111 gives and; any other funct3 gives add.

States:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite = PCWrite = MemReady. Go to DECODE when MemReady, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target). Next state by opcode:
  - lw (0000011) or sw (0100011): MEMADR
  - R-type (0110011): EXECUTER
  - I-type ALU (0010011): EXECUTEI
  - jal (1101111): JAL
  - beq (1100011): BEQ
  - anything else: Illegal=1, go to FETCH
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD if `op[5]`=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB on MemReady, else hold.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in state. Go to FETCH on MemReady, else hold.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, funct. Go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct. Go to ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero. Go to FETCH.

## Timing
- Reset:
  - State goes to FETCH immediately on `rst` rising.
  - While `rst`=1, PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced 0. All other outputs show FETCH values.
- Reset mid-instruction aborts the instruction. No write enable asserts until FETCH sees MemReady after `rst` falls.
- Latency with MemReady tied to 1, FETCH to FETCH: lw 5 cycles, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Outputs stay stable while waiting.
- MemWrite stays high throughout the MEMWRITE wait.
- `op`, `funct3` and `funct7` are only meaningful from DECODE onward; they are ignored in FETCH.
- BEQ samples `Zero` in the same cycle (combinational). PC updates on the next edge.

## Structure
- Package `ctrl_pkg`: state enum, ALUOp enum, and named constants for ALUControl, ImmSrc, ResultSrc, ALUSrcA/B and opcode values. The package is shared with `ctrl`.
- Sub-module `alu_dec` (inputs: ALUOp, funct3, funct7, op[5]; output: ALUControl) is combinational and reusable by `ctrl`.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset: assert `rst` mid-MEMWRITE -> MemWrite=0 immediately. After release: state FETCH, PCWrite=0 until MemReady=1.
- lw, MemReady=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with ResultSrc=01 in cycle 5 only. ImmSrc=00.
- sw, MemReady low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, ImmSrc=01, then FETCH.
- R-type sub (funct3=000, funct7=1) -> ALUControl=001 in EXECUTER, RegWrite in ALUWB. The same encoding with op=0010011 gives 000.
- beq: Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0. ImmSrc=10. 3 cycles total.
- jal: PCWrite=1 in JAL, ResultSrc=00, ImmSrc=11, RegWrite=1 next cycle. op=1111111 -> Illegal pulses 1 cycle in DECODE, then FETCH.
